// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic slice streamer: default geometry,
// default A/B base addresses and the slice-reader state and index-mode enums.
package systolic_pkg;

   localparam int DFLT_DATA_WIDTH = 64;
   localparam int DFLT_SLICE_LEN  = 32;
   localparam int DFLT_DEPTH      = 4096;

   // IMG_BASEADDR is a byte address; memory words are 8 bytes wide, so the
   // B operand region starts at word IMG_BASEADDR/8.
   localparam int IMG_BASEADDR    = 16384;
   localparam int DFLT_BASE_A     = 0;
   localparam int DFLT_BASE_B     = IMG_BASEADDR / 8;

   typedef enum logic [1:0] {
      RD_IDLE  = 2'd0,
      RD_RUN   = 2'd1,
      RD_DRAIN = 2'd2
   } rd_state_e;

   // OUTER readers address by the pair's outer index i (A operand),
   // INNER readers by the inner index j (B operand).
   typedef enum logic {
      IDX_OUTER = 1'b0,
      IDX_INNER = 1'b1
   } idx_mode_e;

endpackage

// File: rtl/slice_reader.sv
// One output channel: walks the (i, j, k) pair/beat space, issues one memory
// read per cycle while the 2-entry output FIFO has room, and presents the
// returned words on a valid/ready stream.
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   RD_IDLE  | waiting for go; FIFO empty, no reads in flight
//   RD_RUN   | issuing reads, one per cycle whenever the FIFO has room
//   RD_DRAIN | all reads issued; waiting for the FIFO to empty
module slice_reader
   import systolic_pkg::*;
#(
   parameter int        DATA_WIDTH = DFLT_DATA_WIDTH,
   parameter int        SLICE_LEN  = DFLT_SLICE_LEN,
   parameter int        ADDR_W     = 12,
   parameter int        BASE       = 0,
   parameter int        CNT_W      = 8,
   parameter idx_mode_e IDX_MODE   = IDX_OUTER
) (
   input  logic                  s_clk,
   input  logic                  s_rst_n,
   input  logic                  go,
   input  logic [CNT_W-1:0]      n_outer,
   input  logic [CNT_W-1:0]      n_inner,
   output logic                  rd_en,
   output logic [ADDR_W-1:0]     rd_addr,
   input  logic [DATA_WIDTH-1:0] rd_data,
   output logic                  m_valid,
   output logic [DATA_WIDTH-1:0] m_data,
   output logic                  m_last,
   input  logic                  m_ready,
   output logic                  active_nxt
);

   localparam int                BEAT_W    = $clog2(SLICE_LEN);
   localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(SLICE_LEN - 1);

   rd_state_e             state_q, state_d;
   logic [BEAT_W-1:0]     beat_q, beat_d;
   logic [CNT_W-1:0]      outer_q, outer_d;
   logic [CNT_W-1:0]      inner_q, inner_d;
   logic                  rd_vld_q, rd_vld_d;
   logic                  rd_last_q, rd_last_d;
   logic [DATA_WIDTH-1:0] fifo_data_q [2];
   logic [DATA_WIDTH-1:0] fifo_data_d [2];
   logic [1:0]            fifo_last_q, fifo_last_d;
   logic                  wr_ptr_q, wr_ptr_d;
   logic                  rd_ptr_q, rd_ptr_d;
   logic [1:0]            count_q, count_d;

   logic                  issue, pop, push, fifo_pop;
   logic                  beat_end, inner_end, outer_end;
   logic [CNT_W-1:0]      slice_idx;

   // Address of the beat being issued; wraps naturally at ADDR_W bits
   // (DEPTH is a power of two, so this equals the modulo-DEPTH address).
   assign slice_idx = (IDX_MODE == IDX_OUTER) ? outer_q : inner_q;
   assign rd_addr   = ADDR_W'(BASE) + ADDR_W'(slice_idx) * ADDR_W'(SLICE_LEN)
                    + ADDR_W'(beat_q);

   // Output head: FIFO entry if one is stored, otherwise the word arriving
   // from memory this cycle (bypass keeps first-beat latency at one read).
   always_comb begin
      m_valid = (count_q != 2'd0) || rd_vld_q;
      m_data  = (count_q != 2'd0) ? fifo_data_q[rd_ptr_q] : rd_data;
      m_last  = (count_q != 2'd0) ? fifo_last_q[rd_ptr_q] : rd_last_q;
   end

   // FIFO bookkeeping, read issue, counters and next state.
   always_comb begin
      state_d     = state_q;
      beat_d      = beat_q;
      outer_d     = outer_q;
      inner_d     = inner_q;
      fifo_data_d = fifo_data_q;
      fifo_last_d = fifo_last_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;

      pop      = m_valid && m_ready;
      fifo_pop = pop && (count_q != 2'd0);
      push     = rd_vld_q && !((count_q == 2'd0) && pop);

      // Room accounts for the read already in flight, so a stalled consumer
      // can never overflow the two entries.
      issue = (state_q == RD_RUN) &&
              ((count_q == 2'd0) || ((count_q == 2'd1) && !rd_vld_q));
      rd_en = issue;

      beat_end  = (beat_q == BEAT_LAST);
      inner_end = (inner_q == n_inner - CNT_W'(1));
      outer_end = (outer_q == n_outer - CNT_W'(1));

      rd_vld_d  = issue;
      rd_last_d = issue && beat_end;

      if (push) begin
         fifo_data_d[wr_ptr_q] = rd_data;
         fifo_last_d[wr_ptr_q] = rd_last_q;
         wr_ptr_d              = !wr_ptr_q;
      end
      if (fifo_pop) begin
         rd_ptr_d = !rd_ptr_q;
      end
      count_d = count_q + {1'b0, push} - {1'b0, fifo_pop};

      case (state_q)
         RD_IDLE: begin
            if (go) begin
               state_d = RD_RUN;
               beat_d  = '0;
               inner_d = '0;
               outer_d = '0;
            end
         end
         RD_RUN: begin
            if (issue) begin
               if (!beat_end) begin
                  beat_d = beat_q + BEAT_W'(1);
               end else begin
                  beat_d = '0;
                  if (!inner_end) begin
                     inner_d = inner_q + CNT_W'(1);
                  end else begin
                     inner_d = '0;
                     if (!outer_end) begin
                        outer_d = outer_q + CNT_W'(1);
                     end else begin
                        outer_d = '0;
                        state_d = RD_DRAIN;
                     end
                  end
               end
            end
         end
         RD_DRAIN: begin
            if (count_d == 2'd0) begin
               state_d = RD_IDLE;
            end
         end
         default: state_d = RD_IDLE;
      endcase
   end

   assign active_nxt = (state_d != RD_IDLE);

   // State, counter and FIFO registers; reset discards anything in flight.
   always_ff @(posedge s_clk or negedge s_rst_n) begin
      if (!s_rst_n) begin
         state_q     <= RD_IDLE;
         beat_q      <= '0;
         outer_q     <= '0;
         inner_q     <= '0;
         rd_vld_q    <= 1'b0;
         rd_last_q   <= 1'b0;
         fifo_data_q <= '{default: '0};
         fifo_last_q <= '0;
         wr_ptr_q    <= 1'b0;
         rd_ptr_q    <= 1'b0;
         count_q     <= '0;
      end else begin
         state_q     <= state_d;
         beat_q      <= beat_d;
         outer_q     <= outer_d;
         inner_q     <= inner_d;
         rd_vld_q    <= rd_vld_d;
         rd_last_q   <= rd_last_d;
         fifo_data_q <= fifo_data_d;
         fifo_last_q <= fifo_last_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
      end
   end

endmodule

// File: rtl/systolic_slice_streamer.sv
// Top of the slice streamer: operand memory (one write port, one read port
// per channel, read-first), run configuration capture, busy/done, and the
// two slice readers (A = outer index, B = inner index).
module systolic_slice_streamer
   import systolic_pkg::*;
#(
   parameter int DATA_WIDTH = DFLT_DATA_WIDTH,
   parameter int SLICE_LEN  = DFLT_SLICE_LEN,
   parameter int DEPTH      = DFLT_DEPTH,
   parameter int ADDR_W     = $clog2(DEPTH),
   parameter int BASE_A     = DFLT_BASE_A,
   parameter int BASE_B     = DFLT_BASE_B,
   parameter int CNT_W      = 8
) (
   input  logic                  s_clk,
   input  logic                  s_rst_n,
   input  logic                  wr_en,
   input  logic [ADDR_W-1:0]     wr_addr,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  start,
   input  logic [CNT_W-1:0]      cfg_a_slices,
   input  logic [CNT_W-1:0]      cfg_b_slices,
   output logic                  a_valid,
   output logic [DATA_WIDTH-1:0] a_data,
   output logic                  a_last,
   input  logic                  a_ready,
   output logic                  b_valid,
   output logic [DATA_WIDTH-1:0] b_data,
   output logic                  b_last,
   input  logic                  b_ready,
   output logic                  busy,
   output logic                  done
);

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];

   logic [DATA_WIDTH-1:0] a_rd_data_q, a_rd_data_d;
   logic [DATA_WIDTH-1:0] b_rd_data_q, b_rd_data_d;
   logic [CNT_W-1:0]      na_q, na_d;
   logic [CNT_W-1:0]      nb_q, nb_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;

   logic                  start_acc, run_go;
   logic                  a_rd_en, b_rd_en;
   logic [ADDR_W-1:0]     a_rd_addr, b_rd_addr;
   logic                  a_active_nxt, b_active_nxt;

   // Memory write port; contents are deliberately not reset.
   always_ff @(posedge s_clk) begin
      if (wr_en) begin
         mem_q[wr_addr] <= wr_data;
      end
   end

   // Per-channel synchronous read; holds the last word when no read issues.
   // A same-cycle write is not visible here, giving read-first behaviour.
   always_comb begin
      a_rd_data_d = a_rd_en ? mem_q[a_rd_addr] : a_rd_data_q;
      b_rd_data_d = b_rd_en ? mem_q[b_rd_addr] : b_rd_data_q;
   end

   // An empty run (NA or NB zero) still raises busy for one cycle but never
   // wakes the readers.
   assign start_acc = start && !busy_q;
   assign run_go    = start_acc && (cfg_a_slices != '0) && (cfg_b_slices != '0);

   // Config capture and busy/done sequencing.
   always_comb begin
      na_d = start_acc ? cfg_a_slices : na_q;
      nb_d = start_acc ? cfg_b_slices : nb_q;
      if (start_acc) begin
         busy_d = 1'b1;
      end else begin
         busy_d = busy_q && (a_active_nxt || b_active_nxt);
      end
      done_d = busy_q && !busy_d;
   end

   // Control and read-data registers.
   always_ff @(posedge s_clk or negedge s_rst_n) begin
      if (!s_rst_n) begin
         a_rd_data_q <= '0;
         b_rd_data_q <= '0;
         na_q        <= '0;
         nb_q        <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         a_rd_data_q <= a_rd_data_d;
         b_rd_data_q <= b_rd_data_d;
         na_q        <= na_d;
         nb_q        <= nb_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   assign busy = busy_q;
   assign done = done_q;

   slice_reader #(
      .DATA_WIDTH (DATA_WIDTH),
      .SLICE_LEN  (SLICE_LEN),
      .ADDR_W     (ADDR_W),
      .BASE       (BASE_A),
      .CNT_W      (CNT_W),
      .IDX_MODE   (IDX_OUTER)
   ) u_reader_a (
      .s_clk      (s_clk),
      .s_rst_n    (s_rst_n),
      .go         (run_go),
      .n_outer    (na_q),
      .n_inner    (nb_q),
      .rd_en      (a_rd_en),
      .rd_addr    (a_rd_addr),
      .rd_data    (a_rd_data_q),
      .m_valid    (a_valid),
      .m_data     (a_data),
      .m_last     (a_last),
      .m_ready    (a_ready),
      .active_nxt (a_active_nxt)
   );

   slice_reader #(
      .DATA_WIDTH (DATA_WIDTH),
      .SLICE_LEN  (SLICE_LEN),
      .ADDR_W     (ADDR_W),
      .BASE       (BASE_B),
      .CNT_W      (CNT_W),
      .IDX_MODE   (IDX_INNER)
   ) u_reader_b (
      .s_clk      (s_clk),
      .s_rst_n    (s_rst_n),
      .go         (run_go),
      .n_outer    (na_q),
      .n_inner    (nb_q),
      .rd_en      (b_rd_en),
      .rd_addr    (b_rd_addr),
      .rd_data    (b_rd_data_q),
      .m_valid    (b_valid),
      .m_data     (b_data),
      .m_last     (b_last),
      .m_ready    (b_ready),
      .active_nxt (b_active_nxt)
   );

endmodule

// File: tb/tb_systolic_slice_streamer.sv
// Bench for systolic_slice_streamer: a queue-based reference of the tiled
// slice order, random ready patterns, and directed reset/wrap/ignore cases.
module tb_systolic_slice_streamer;

   localparam int DW       = 64;
   localparam int SL       = 32;
   localparam int DEPTH    = 4096;
   localparam int AW       = 12;
   localparam int CW       = 8;
   localparam int BASE_A   = 0;
   localparam int BASE_B   = 2048;
   localparam int BASE_B_W = DEPTH - 16;

   logic          s_clk = 1'b0;
   logic          s_rst_n = 1'b0;
   logic          wr_en = 1'b0;
   logic [AW-1:0] wr_addr = '0;
   logic [DW-1:0] wr_data = '0;
   logic          start = 1'b0;
   logic [CW-1:0] cfg_a_slices = '0, cfg_b_slices = '0;
   logic          a_valid, a_last, b_valid, b_last, busy, done;
   logic [DW-1:0] a_data, b_data;
   logic          a_ready = 1'b1, b_ready = 1'b1;

   logic          start_w = 1'b0;
   logic [CW-1:0] cfg_a_w = '0, cfg_b_w = '0;
   logic          a_valid_w, a_last_w, b_valid_w, b_last_w, busy_w, done_w;
   logic [DW-1:0] a_data_w, b_data_w;
   logic          a_ready_w = 1'b1, b_ready_w = 1'b1;

   always #5 s_clk = ~s_clk;

   systolic_slice_streamer u_dut (
      .s_clk(s_clk), .s_rst_n(s_rst_n),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .start(start), .cfg_a_slices(cfg_a_slices), .cfg_b_slices(cfg_b_slices),
      .a_valid(a_valid), .a_data(a_data), .a_last(a_last), .a_ready(a_ready),
      .b_valid(b_valid), .b_data(b_data), .b_last(b_last), .b_ready(b_ready),
      .busy(busy), .done(done)
   );

   systolic_slice_streamer #(.BASE_B(BASE_B_W)) u_dut_w (
      .s_clk(s_clk), .s_rst_n(s_rst_n),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .start(start_w), .cfg_a_slices(cfg_a_w), .cfg_b_slices(cfg_b_w),
      .a_valid(a_valid_w), .a_data(a_data_w), .a_last(a_last_w), .a_ready(a_ready_w),
      .b_valid(b_valid_w), .b_data(b_data_w), .b_last(b_last_w), .b_ready(b_ready_w),
      .busy(busy_w), .done(done_w)
   );

   logic [DW-1:0] ref_mem [DEPTH];
   logic [DW:0]   exp_a [$];
   logic [DW:0]   exp_b [$];
   int            n_checks = 0;
   int            n_errors = 0;

   task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Expected beat streams: for every pair (i, j) in row-major order the A
   // channel replays slice i and the B channel slice j.
   task automatic build_model(input int na, input int nb);
      exp_a.delete();
      exp_b.delete();
      for (int i = 0; i < na; i++)
         for (int j = 0; j < nb; j++)
            for (int k = 0; k < SL; k++) begin
               exp_a.push_back({k == SL - 1, ref_mem[AW'((BASE_A + i * SL + k) % DEPTH)]});
               exp_b.push_back({k == SL - 1, ref_mem[AW'((BASE_B + j * SL + k) % DEPTH)]});
            end
   endtask

   task automatic run(input int na, input int nb, input int pct_a, input int pct_b,
                      input int inj_cyc, input int inj_na, input int inj_nb);
      int          cyc, last_a, last_b, n, budget, exp_done;
      bit          done_seen;
      logic        pv_a, pr_a, pv_b, pr_b;
      logic [DW:0] pd_a, pd_b;
      build_model(na, nb);
      n = na * nb * SL;
      budget = 20 * n + 50;
      @(negedge s_clk);
      start = 1'b1;
      cfg_a_slices = CW'(na);
      cfg_b_slices = CW'(nb);
      a_ready = 1'b1;
      b_ready = 1'b1;
      @(negedge s_clk);
      cyc = 1; last_a = 0; last_b = 0; done_seen = 1'b0;
      pv_a = 1'b0; pr_a = 1'b0; pv_b = 1'b0; pr_b = 1'b0; pd_a = '0; pd_b = '0;
      check("busy_rise", 72'(busy), 72'(1));
      while (!done_seen && cyc < budget) begin
         start = (cyc == inj_cyc);
         cfg_a_slices = start ? CW'(inj_na) : CW'($urandom_range(255));
         cfg_b_slices = start ? CW'(inj_nb) : CW'($urandom_range(255));
         a_ready = (int'($urandom_range(99)) < pct_a);
         b_ready = (int'($urandom_range(99)) < pct_b);
         if (pv_a && !pr_a) check("a_hold", 72'({a_valid, a_last, a_data}), 72'({1'b1, pd_a}));
         if (pv_b && !pr_b) check("b_hold", 72'({b_valid, b_last, b_data}), 72'({1'b1, pd_b}));
         if (done) begin
            done_seen = 1'b1;
            exp_done = (n == 0) ? 2 : ((last_a > last_b) ? last_a : last_b) + 1;
            check("done_time", 72'(cyc), 72'(exp_done));
            check("busy_at_done", 72'(busy), 72'(0));
            check("a_left", 72'(exp_a.size()), 72'(0));
            check("b_left", 72'(exp_b.size()), 72'(0));
            if (pct_a == 100 && pct_b == 100) check("done_full_rate", 72'(cyc), 72'(2 + n));
            if (pct_b == 100 && n > 0) check("b_last_cycle", 72'(last_b), 72'(1 + n));
         end else begin
            check("busy_run", 72'(busy), 72'(1));
         end
         if (a_valid && a_ready) begin
            if (exp_a.size() == 0) check("a_extra", 72'(a_valid), 72'(0));
            else check("a_beat", 72'({a_last, a_data}), 72'(exp_a.pop_front()));
            last_a = cyc;
         end
         if (b_valid && b_ready) begin
            if (exp_b.size() == 0) check("b_extra", 72'(b_valid), 72'(0));
            else check("b_beat", 72'({b_last, b_data}), 72'(exp_b.pop_front()));
            last_b = cyc;
         end
         pv_a = a_valid; pr_a = a_ready; pd_a = {a_last, a_data};
         pv_b = b_valid; pr_b = b_ready; pd_b = {b_last, b_data};
         if (!done_seen) begin
            @(negedge s_clk);
            cyc++;
         end
      end
      if (!done_seen) check("done_timeout", 72'(done), 72'(1));
      start = 1'b0;
      a_ready = 1'b1;
      b_ready = 1'b1;
      @(negedge s_clk);
      check("done_pulse", 72'(done), 72'(0));
   endtask

   initial begin
      int cnt, cyc, k;

      // Reset values.
      #1;
      check("rst_a", 72'({a_valid, a_last, a_data}), 72'(0));
      check("rst_b", 72'({b_valid, b_last, b_data}), 72'(0));
      check("rst_ctl", 72'({busy, done}), 72'(0));
      repeat (2) @(negedge s_clk);
      s_rst_n = 1'b1;

      // Load: low half is the word address, high half random.
      for (int x = 0; x < DEPTH; x++) begin
         @(negedge s_clk);
         ref_mem[x] = {$urandom(), 32'(x)};
         wr_en = 1'b1;
         wr_addr = AW'(x);
         wr_data = ref_mem[x];
      end
      @(negedge s_clk);
      wr_en = 1'b0;

      run(2, 3, 100, 100, 0, 0, 0);
      run(2, 3, 40, 100, 0, 0, 0);
      run(0, 5, 100, 100, 0, 0, 0);
      run(4, 0, 100, 100, 0, 0, 0);
      run(2, 3, 100, 100, 10, 1, 1);

      // Reset in the middle of a run, at A beat 40.
      @(negedge s_clk);
      start = 1'b1; cfg_a_slices = 8'd2; cfg_b_slices = 8'd3;
      @(negedge s_clk);
      start = 1'b0;
      cnt = 0; cyc = 0;
      while (cnt < 40 && cyc < 200) begin
         if (a_valid && a_ready) cnt++;
         @(negedge s_clk);
         cyc++;
      end
      check("midrun_valid", 72'(a_valid), 72'(1));
      s_rst_n = 1'b0;
      #1;
      check("midrst_a", 72'({a_valid, a_last, a_data}), 72'(0));
      check("midrst_b", 72'({b_valid, b_last, b_data}), 72'(0));
      check("midrst_ctl", 72'({busy, done}), 72'(0));
      repeat (2) @(negedge s_clk);
      s_rst_n = 1'b1;
      run(1, 1, 100, 100, 0, 0, 0);

      // Address wrap on the B channel of the second instance.
      @(negedge s_clk);
      start_w = 1'b1; cfg_a_w = 8'd1; cfg_b_w = 8'd1;
      @(negedge s_clk);
      start_w = 1'b0;
      k = 0; cyc = 0;
      while (!done_w && cyc < 200) begin
         if (b_valid_w && b_ready_w) begin
            if (k < SL)
               check("wrap_b", 72'({b_last_w, b_data_w}),
                     72'({k == SL - 1, ref_mem[AW'((BASE_B_W + k) % DEPTH)]}));
            else
               check("wrap_extra", 72'(b_valid_w), 72'(0));
            k++;
         end
         @(negedge s_clk);
         cyc++;
      end
      check("wrap_count", 72'(k), 72'(SL));
      check("wrap_done", 72'(done_w), 72'(1));

      // Random configurations with random back-pressure on both channels.
      for (int r = 0; r < 4; r++)
         run(int'($urandom_range(1, 3)), int'($urandom_range(1, 3)),
             int'($urandom_range(30, 100)), int'($urandom_range(30, 100)), 0, 0, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/systolic_slice_streamer.md
# systolic_slice_streamer

Parametrised generator for systolic-array matrix slices. It holds matrix A and B words in an internal synchronous-read memory loaded through a write port. On `start` it streams A and B slices on two independent valid/ready channels in tiled order: each A slice is repeated once per B slice, which gives the outer-product reuse the array needs. It sits between the load path (DDR/DMA writer) and the systolic array input skew logic.

## Interface
- `DATA_WIDTH`, 64: width of one memory word / stream beat
- `SLICE_LEN`, 32: beats per slice, ≥2
- `DEPTH`, 4096: memory words
- `ADDR_W`, $clog2(DEPTH): memory address width
- `BASE_A`, 0: word address of A slice 0
- `BASE_B`, 2048: word address of B slice 0
- `CNT_W`, 8: width of slice-count config
- `s_clk` in 1: clock
- `s_rst_n` in 1: asynchronous, active-low reset
- `wr_en` in 1: memory write strobe
- `wr_addr` in ADDR_W: write address
- `wr_data` in DATA_WIDTH: write data
- `start` in 1: one-cycle pulse; samples config, begins a run
- `cfg_a_slices` in CNT_W: number of A slices (NA)
- `cfg_b_slices` in CNT_W: number of B slices (NB)
- `a_valid`/`b_valid` out 1: beat available
- `a_data`/`b_data` out DATA_WIDTH: beat payload
- `a_last`/`b_last` out 1: final beat of the current slice
- `a_ready`/`b_ready` in 1: downstream accepts
- `busy` out 1: run in progress
- `done` out 1: one-cycle pulse, run complete

## Operation
- Run order: pair p = i*NB + j for i in 0..NA-1 and j in 0..NB-1.
  - A channel emits slice i for pair p; B channel emits slice j.
  - Each channel emits NA*NB slices of SLICE_LEN beats.
- Beat k of A slice i reads address `(BASE_A + i*SLICE_LEN + k) mod DEPTH`. B uses the same rule with `BASE_B` and j. Address arithmetic is ADDR_W bits and wraps.
- Channels are fully independent; either may run ahead of the other.
- Each channel is one `slice_reader` FSM with states IDLE → RUN → DRAIN → IDLE.
  - RUN: issues one memory read per cycle while the output FIFO has room. Room counts in-flight reads, so there is no overflow.
  - After the last read is issued: go to DRAIN.
  - DRAIN: wait until the FIFO is empty, then go to IDLE.
- Each channel has a 2-entry output FIFO fed by the 1-cycle memory read. This sustains 1 beat/cycle with ready held high.
- Handshake: a beat transfers when valid && ready. While valid is high and ready is low, data and last stay stable. Valid never drops without a transfer.
- `busy` rises the cycle after an accepted `start` and stays high until either channel is non-IDLE no longer holds. `done` pulses for one cycle when `busy` falls.
- `start` while `busy` is ignored. Config is sampled only on an accepted `start`.
- NA = 0 or NB = 0: no beats are emitted; `busy` pulses for one cycle and `done` pulses the next cycle.
- Memory is read-first: a write to an address read in the same cycle returns the old data. Writes are allowed at any time. Coherence during a run is the loader's responsibility.

## Timing
- Reset values: every valid, last, data, `busy` and `done` is 0; FSMs are IDLE; FIFOs are empty; counters are 0. Memory contents are not reset.
- Reset asserted mid-run aborts immediately and discards any in-flight data. After release the block waits for a new `start`.
- Latency with ready high: `start` accepted at cycle t → `busy`=1 at t+1 → first beat valid at t+2.
- With ready held high, beats are back-to-back and slices are back-to-back with no bubble. A full run ends with its last beat at t+1+NA*NB*SLICE_LEN.
- `done` is asserted one cycle after the final beat transfers on the later of the two channels.
- `a_last` is high on beats k = SLICE_LEN-1 only.

## Structure
- Shared package `systolic_pkg`:
  - `DATA_WIDTH`, `SLICE_LEN`, and the slice-reader FSM state enum.
  - Default `BASE_A`/`BASE_B`, consistent with `IMG_BASEADDR/8`.
- Sub-module `slice_reader`: FSM, slice/beat/pair counters, address generation, read issue and the 2-entry FIFO. It is instantiated twice, with an "outer" (A) or "inner" (B) index-mode parameter.
- The top level holds the memory array, config capture, and `busy`/`done` logic.

## Test plan
- Load ramp mem[x]=x; NA=2, NB=3, SLICE_LEN=32, ready high:
  - A beats = 0..31 ×3, then 32..63 ×3.
  - B beats = 2048..2143 twice.
  - `done` at start+1+192+1.
- Random ready on A only, B ready high: A data sequence matches the ideal; valid/data stay stable while stalled; B completes early; `done` waits for A.
- NA=0, NB=5: no valid asserted; `busy` one cycle; `done` pulse.
- BASE_B = DEPTH-16, NB=1: B beats 17..32 read addresses 0..15 (wrap).
- `s_rst_n` low at beat 40 of a run: all outputs go to 0 that cycle. After release, a new `start` with NA=NB=1 yields exactly 32 beats per channel.
- Second `start` at busy cycle 10 with a different config: ignored; the run matches the first config.
